// File: rtl/mem_arbiter.sv
// Byte-serial memory bus arbiter: fetch (IF) and load/store (LS) requests are turned into
// per-byte RAM/IO accesses, with IO-write back-pressure and freeze/replay while rdy_in is low.
module mem_arbiter #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_clear,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, IOWAIT} state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] buf_q;
    logic [2:0]  len;
    logic [2:0]  issue_cnt;
    logic [2:0]  done_cnt;
    logic [1:0]  pres_idx_p0;
    logic        pres_vld_p0;
    logic [1:0]  idx_p1;
    logic        vld_p1;
    logic        is_if;
    logic        wr_q;

    logic [2:0]  wr_next_cnt;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic [7:0]  wr_byte;
    logic [31:0] rd_merged;

    function automatic logic [2:0] size_len(input logic [1:0] s);
        case (s)
            2'b00:   size_len = 3'd1;
            2'b01:   size_len = 3'd2;
            default: size_len = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] b, input logic [7:0] d,
                                               input logic [1:0] idx);
        merge_byte = b | (32'(d) << {idx, 3'b000});
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        is_io = (a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
    endfunction

    // A write byte counts as done only if it was actually driven with rdy_in high.
    always_comb begin
        wr_next_cnt = done_cnt + {2'b00, (state == WRITE) && pres_vld_p0};
        wr_addr     = base + 32'(wr_next_cnt);
        wr_byte     = byte_sel(wdata, wr_next_cnt[1:0]);
        rd_addr     = base + 32'(issue_cnt);
        rd_merged   = merge_byte(buf_q, mem_din, idx_p1);
    end

    assign mem_wr = wr_q & rdy_in;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            base        <= '0;
            wdata       <= '0;
            buf_q       <= '0;
            len         <= '0;
            issue_cnt   <= '0;
            done_cnt    <= '0;
            pres_idx_p0 <= '0;
            pres_vld_p0 <= 1'b0;
            idx_p1      <= '0;
            vld_p1      <= 1'b0;
            is_if       <= 1'b0;
            wr_q        <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= '0;
            if_done     <= 1'b0;
            if_data     <= '0;
            ls_done     <= 1'b0;
            ls_rdata    <= '0;
        end else if (!rdy_in) begin
            // Bus is lost: drop in-flight reads and rewind issue to the first uncaptured byte.
            pres_vld_p0 <= 1'b0;
            vld_p1      <= 1'b0;
            wr_q        <= 1'b0;
            if (state == READ) issue_cnt <= done_cnt;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    buf_q    <= '0;
                    done_cnt <= '0;
                    vld_p1   <= 1'b0;
                    if (ls_req) begin
                        base  <= ls_addr;
                        wdata <= ls_wdata;
                        len   <= size_len(ls_size);
                        is_if <= 1'b0;
                        if (ls_wr) begin
                            if (is_io(ls_addr) && io_buffer_full) begin
                                state       <= IOWAIT;
                                pres_vld_p0 <= 1'b0;
                            end else begin
                                state       <= WRITE;
                                mem_a       <= ls_addr;
                                mem_dout    <= ls_wdata[7:0];
                                wr_q        <= 1'b1;
                                pres_vld_p0 <= 1'b1;
                            end
                        end else begin
                            state       <= READ;
                            mem_a       <= ls_addr;
                            pres_idx_p0 <= 2'd0;
                            pres_vld_p0 <= 1'b1;
                            issue_cnt   <= 3'd1;
                        end
                    end else if (if_req && !if_clear) begin
                        base        <= if_addr;
                        len         <= 3'd4;
                        is_if       <= 1'b1;
                        state       <= READ;
                        mem_a       <= if_addr;
                        pres_idx_p0 <= 2'd0;
                        pres_vld_p0 <= 1'b1;
                        issue_cnt   <= 3'd1;
                    end
                end
                READ: begin
                    if (is_if && if_clear) begin
                        state       <= IDLE;
                        mem_a       <= '0;
                        pres_vld_p0 <= 1'b0;
                        vld_p1      <= 1'b0;
                    end else begin
                        // p0 = address on the bus, p1 = address the RAM sampled last edge
                        vld_p1 <= pres_vld_p0;
                        idx_p1 <= pres_idx_p0;
                        if (vld_p1) begin
                            buf_q    <= rd_merged;
                            done_cnt <= done_cnt + 3'd1;
                        end
                        if (vld_p1 && ({1'b0, idx_p1} == len - 3'd1)) begin
                            state       <= IDLE;
                            mem_a       <= '0;
                            pres_vld_p0 <= 1'b0;
                            vld_p1      <= 1'b0;
                            if (is_if) begin
                                if_done <= 1'b1;
                                if_data <= rd_merged;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rd_merged;
                            end
                        end else if (issue_cnt < len) begin
                            mem_a       <= rd_addr;
                            pres_idx_p0 <= issue_cnt[1:0];
                            pres_vld_p0 <= 1'b1;
                            issue_cnt   <= issue_cnt + 3'd1;
                        end else begin
                            pres_vld_p0 <= 1'b0;
                        end
                    end
                end
                WRITE, IOWAIT: begin
                    done_cnt <= wr_next_cnt;
                    if (wr_next_cnt == len) begin
                        state       <= IDLE;
                        wr_q        <= 1'b0;
                        mem_a       <= '0;
                        pres_vld_p0 <= 1'b0;
                        ls_done     <= 1'b1;
                    end else if (is_io(wr_addr) && io_buffer_full) begin
                        state       <= IOWAIT;
                        wr_q        <= 1'b0;
                        pres_vld_p0 <= 1'b0;
                    end else begin
                        state       <= WRITE;
                        mem_a       <= wr_addr;
                        mem_dout    <= wr_byte;
                        wr_q        <= 1'b1;
                        pres_vld_p0 <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model and an IO write log.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_full;
    logic        if_req, if_clear, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done, busy;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;

    int total = 0;
    int bad   = 0;
    int io_cnt = 0;
    logic [7:0] io_last = 8'h00;
    logic [7:0] ram [0:65535];

    mem_arbiter #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_full),
        .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear), .if_done(if_done),
        .if_data(if_data), .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM; returns junk while the debug side owns the bus.
    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_last <= mem_dout;
                io_cnt  <= io_cnt + 1;
            end else begin
                ram[mem_a[15:0]] <= mem_dout;
            end
        end
        mem_din <= rdy ? ram[mem_a[15:0]] : 8'hEE;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick; tick;
        total++; if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin bad++;
            $display("FAIL reset_bus: got a=%h wr=%b dout=%h want 0", mem_a, mem_wr, mem_dout); end
        total++; if (if_done !== 1'b0 || ls_done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL reset_ctl: got if_done=%b ls_done=%b busy=%b want 0", if_done, ls_done, busy); end
        total++; if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin bad++;
            $display("FAIL reset_data: got if=%h ls=%h want 0", if_data, ls_rdata); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_if_fetch;
        if_addr = 32'h100; if_req = 1'b1;
        tick;
        total++; if (mem_a !== 32'h100 || busy !== 1'b1 || mem_wr !== 1'b0) begin bad++;
            $display("FAIL fetch_a0: got a=%h busy=%b wr=%b want 100 1 0", mem_a, busy, mem_wr); end
        for (int i = 1; i < 4; i++) begin
            tick;
            total++; if (mem_a !== 32'(32'h100 + i)) begin bad++;
                $display("FAIL fetch_addr%0d: got %h want %h", i, mem_a, 32'h100 + i); end
        end
        tick;
        total++; if (if_done !== 1'b0) begin bad++;
            $display("FAIL fetch_early: got if_done=%b want 0 at cycle 4", if_done); end
        tick;
        total++; if (if_done !== 1'b1) begin bad++;
            $display("FAIL fetch_latency: got if_done=%b want 1 at cycle 5", if_done); end
        total++; if (if_data !== 32'h0000_0513) begin bad++;
            $display("FAIL fetch_data: got %h want 00000513", if_data); end
        if_req = 1'b0;
        tick;
        total++; if (if_done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL fetch_pulse: got if_done=%b busy=%b want 0 0", if_done, busy); end
    endtask

    task automatic test_priority;
        int cyc;
        if_addr = 32'h300; if_req = 1'b1;
        ls_addr = 32'h2000; ls_wr = 1'b0; ls_size = 2'b01; ls_req = 1'b1;
        tick;
        total++; if (mem_a !== 32'h2000) begin bad++;
            $display("FAIL prio_ls_first: got a=%h want 00002000", mem_a); end
        tick; tick; tick;
        total++; if (ls_done !== 1'b1 || ls_rdata !== 32'h0000_1234) begin bad++;
            $display("FAIL prio_ls_half: got done=%b data=%h want 1 00001234", ls_done, ls_rdata); end
        total++; if (mem_a !== 32'h0 || busy !== 1'b0) begin bad++;
            $display("FAIL prio_idle: got a=%h busy=%b want 0 0", mem_a, busy); end
        ls_req = 1'b0;
        tick;
        total++; if (mem_a !== 32'h300 || busy !== 1'b1) begin bad++;
            $display("FAIL prio_if_accept: got a=%h busy=%b want 300 1", mem_a, busy); end
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick; cyc++;
            if (if_done) break;
        end
        total++; if (if_done !== 1'b1 || cyc != 5 || if_data !== 32'h4433_2211) begin bad++;
            $display("FAIL prio_if_data: got done=%b cyc=%0d data=%h want 1 5 44332211", if_done, cyc, if_data); end
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_store_word;
        logic [7:0] exp_b [4];
        int cyc;
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ls_addr = 32'h1000; ls_wr = 1'b1; ls_size = 2'b10; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++; if (mem_wr !== 1'b1 || mem_a !== 32'(32'h1000 + i) || mem_dout !== exp_b[i]) begin bad++;
                $display("FAIL store_byte%0d: got wr=%b a=%h d=%h want 1 %h %h", i, mem_wr, mem_a, mem_dout,
                         32'h1000 + i, exp_b[i]); end
            if (i == 3) begin
                total++; if (ls_done !== 1'b0) begin bad++;
                    $display("FAIL store_early: got ls_done=%b want 0", ls_done); end
            end
        end
        tick;
        total++; if (ls_done !== 1'b1 || mem_wr !== 1'b0 || mem_a !== 32'h0) begin bad++;
            $display("FAIL store_done: got done=%b wr=%b a=%h want 1 0 0", ls_done, mem_wr, mem_a); end
        ls_wr = 1'b0; ls_wdata = 32'h0;
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            tick; cyc++;
            if (ls_done) break;
        end
        total++; if (ls_done !== 1'b1 || cyc != 6 || ls_rdata !== 32'hDEAD_BEEF) begin bad++;
            $display("FAIL store_readback: got done=%b cyc=%0d data=%h want 1 6 deadbeef", ls_done, cyc, ls_rdata); end
        ls_req = 1'b0;
        tick;
    endtask

    task automatic test_io_store;
        logic saw_wr;
        io_full = 1'b1;
        ls_addr = 32'h3_0000; ls_wr = 1'b1; ls_size = 2'b00; ls_wdata = 32'h41; ls_req = 1'b1;
        saw_wr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (mem_wr !== 1'b0) saw_wr = 1'b1;
        end
        total++; if (saw_wr !== 1'b0 || busy !== 1'b1 || ls_done !== 1'b0) begin bad++;
            $display("FAIL io_stall: got saw_wr=%b busy=%b done=%b want 0 1 0", saw_wr, busy, ls_done); end
        io_full = 1'b0;
        tick;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h3_0000 || mem_dout !== 8'h41) begin bad++;
            $display("FAIL io_write: got wr=%b a=%h d=%h want 1 00030000 41", mem_wr, mem_a, mem_dout); end
        tick;
        total++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin bad++;
            $display("FAIL io_done: got done=%b wr=%b want 1 0", ls_done, mem_wr); end
        total++; if (io_cnt != 1 || io_last !== 8'h41) begin bad++;
            $display("FAIL io_log: got cnt=%0d byte=%h want 1 41", io_cnt, io_last); end
        ls_req = 1'b0; ls_wr = 1'b0;
        tick;
    endtask

    task automatic test_if_clear;
        int cyc;
        logic early;
        if_addr = 32'h400; if_req = 1'b1;
        tick; tick; tick;
        if_clear = 1'b1;
        tick;
        total++; if (busy !== 1'b0 || if_done !== 1'b0 || mem_a !== 32'h0) begin bad++;
            $display("FAIL clear_abort: got busy=%b done=%b a=%h want 0 0 0", busy, if_done, mem_a); end
        if_clear = 1'b0; if_addr = 32'h200;
        cyc = 0;
        early = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick; cyc++;
            if (if_done) break;
        end
        total++; if (if_done !== 1'b1 || cyc != 6 || if_data !== 32'hDDCC_BBAA) begin bad++;
            $display("FAIL clear_refetch: got done=%b cyc=%0d data=%h want 1 6 ddccbbaa", if_done, cyc, if_data); end
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_freeze_read;
        int cyc;
        if_addr = 32'h500; if_req = 1'b1;
        tick; tick; tick; tick;
        rdy = 1'b0;
        tick;
        total++; if (mem_wr !== 1'b0 || busy !== 1'b1 || if_done !== 1'b0) begin bad++;
            $display("FAIL frz_hold: got wr=%b busy=%b done=%b want 0 1 0", mem_wr, busy, if_done); end
        tick; tick;
        rdy = 1'b1;
        tick;
        total++; if (mem_a !== 32'h502) begin bad++;
            $display("FAIL frz_reissue2: got a=%h want 00000502", mem_a); end
        tick;
        total++; if (mem_a !== 32'h503) begin bad++;
            $display("FAIL frz_reissue3: got a=%h want 00000503", mem_a); end
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick; cyc++;
            if (if_done) break;
        end
        total++; if (if_done !== 1'b1 || cyc != 2 || if_data !== 32'h0403_0201) begin bad++;
            $display("FAIL frz_data: got done=%b cyc=%0d data=%h want 1 2 04030201", if_done, cyc, if_data); end
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_freeze_store;
        ls_addr = 32'h1800; ls_wr = 1'b1; ls_size = 2'b01; ls_wdata = 32'h0000_CAFE; ls_req = 1'b1;
        tick;
        total++; if (mem_wr !== 1'b1 || mem_dout !== 8'hFE) begin bad++;
            $display("FAIL fst_first: got wr=%b d=%h want 1 fe", mem_wr, mem_dout); end
        rdy = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++;
            $display("FAIL fst_forced: got wr=%b want 0", mem_wr); end
        tick; tick;
        rdy = 1'b1;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++;
            $display("FAIL fst_stale: got wr=%b want 0", mem_wr); end
        tick;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h1800 || mem_dout !== 8'hFE) begin bad++;
            $display("FAIL fst_re0: got wr=%b a=%h d=%h want 1 1800 fe", mem_wr, mem_a, mem_dout); end
        tick;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h1801 || mem_dout !== 8'hCA) begin bad++;
            $display("FAIL fst_re1: got wr=%b a=%h d=%h want 1 1801 ca", mem_wr, mem_a, mem_dout); end
        tick;
        total++; if (ls_done !== 1'b1 || ram[16'h1800] !== 8'hFE || ram[16'h1801] !== 8'hCA) begin bad++;
            $display("FAIL fst_done: got done=%b m0=%h m1=%h want 1 fe ca", ls_done, ram[16'h1800], ram[16'h1801]); end
        ls_req = 1'b0; ls_wr = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        if_addr = 32'h100; if_req = 1'b1;
        tick; tick;
        rst = 1'b1;
        tick;
        total++; if (busy !== 1'b0 || mem_a !== 32'h0 || if_done !== 1'b0 || if_data !== 32'h0) begin bad++;
            $display("FAIL rstmid_state: got busy=%b a=%h done=%b data=%h want 0 0 0 0", busy, mem_a, if_done, if_data); end
        rst = 1'b0; if_req = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (if_done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL rstmid_nodone: got saw_done=%b busy=%b want 0 0", saw_done, busy); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h00; ram[16'h103] = 8'h00;
        ram[16'h2000] = 8'h34; ram[16'h2001] = 8'h12;
        ram[16'h300] = 8'h11; ram[16'h301] = 8'h22; ram[16'h302] = 8'h33; ram[16'h303] = 8'h44;
        ram[16'h200] = 8'hAA; ram[16'h201] = 8'hBB; ram[16'h202] = 8'hCC; ram[16'h203] = 8'hDD;
        ram[16'h500] = 8'h01; ram[16'h501] = 8'h02; ram[16'h502] = 8'h03; ram[16'h503] = 8'h04;
        rst = 1'b1; rdy = 1'b1; io_full = 1'b0;
        if_req = 1'b0; if_addr = '0; if_clear = 1'b0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
        test_reset;
        test_if_fetch;
        test_priority;
        test_store_word;
        test_io_store;
        test_if_clear;
        test_freeze_read;
        test_freeze_store;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
